// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - hardwired Moore control sequencer (fetch T0-T2, execute T3-T7); optional CTRL_SINGLE_STEP_EN
module control_sequencer #(
    parameter int OPC_LSB = 27,
    parameter int ALUOP_W = 4
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic [31:0]        IR,
    input  logic               CON,
    input  logic               Stop,
`ifdef CTRL_SINGLE_STEP_EN
    input  logic               Step,
`endif
    output logic               Run,
    output logic               InstrDone,
    output logic [ALUOP_W-1:0] AluOp,
    output logic               PCin, MDRin, Zin, Yin, MARin, IRin, CONin, HIin, LOin, OUTPORTin,
    output logic               PCout, MDRout, ZLOout, ZHIout, HIout, LOout, INPORTout, Cout,
    output logic               Gra, Grb, Grc, Rin, Rout, BAout,
    output logic               Read, IncPC, write
);

    localparam logic [4:0] OP_LD   = 5'b00000, OP_LDI  = 5'b00001, OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011, OP_SUB  = 5'b00100, OP_AND  = 5'b01010;
    localparam logic [4:0] OP_OR   = 5'b01011, OP_ADDI = 5'b01100, OP_BR   = 5'b10011;
    localparam logic [4:0] OP_JR   = 5'b10100, OP_IN   = 5'b10110, OP_OUT  = 5'b10111;
    localparam logic [4:0] OP_MFHI = 5'b11000, OP_MFLO = 5'b11001, OP_HALT = 5'b11011;

    typedef enum logic [3:0] {
        RST_S, T0, T1, T2, T3, T4, T5, T6, T7, HALTED, PAUSE
    } state_t;

    state_t     state, state_nx;
    logic [4:0] opc_q;
    logic [4:0] op;
    logic       stop_pend;
    logic       stop_now;
    logic       done;
    logic       is_alu, is_imm, is_mem, is_br;
    logic       unused_ir_bits;

    // Only the opcode field is decoded; register fields are consumed by the datapath.
    assign unused_ir_bits = ^IR;

    // State register; reset aborts any instruction immediately.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) state <= RST_S;
        else       state <= state_nx;
    end

    // Opcode is captured at the end of T3 and held for the remaining execute steps.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset)            opc_q <= 5'd0;
        else if (state == T3) opc_q <= IR[OPC_LSB +: 5];
    end

    // Sticky halt request; only reset clears it.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset)     stop_pend <= 1'b0;
        else if (Stop) stop_pend <= 1'b1;
    end

    // Next-state and control-line decode from the present state.
    always_comb begin
        state_nx  = state;
        done      = 1'b0;
        AluOp     = '0;
        {PCin, MDRin, Zin, Yin, MARin, IRin, CONin, HIin, LOin, OUTPORTin} = '0;
        {PCout, MDRout, ZLOout, ZHIout, HIout, LOout, INPORTout, Cout}     = '0;
        {Gra, Grb, Grc, Rin, Rout, BAout}                                  = '0;
        {Read, IncPC, write}                                               = '0;

        // In T3 the opcode register is still loading, so decode straight from IR.
        op       = (state == T3) ? IR[OPC_LSB +: 5] : opc_q;
        stop_now = stop_pend | Stop;
        is_alu   = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
        is_imm   = (op == OP_ADDI) || (op == OP_LDI);
        is_mem   = (op == OP_LD) || (op == OP_ST);
        is_br    = (op == OP_BR);

        case (state)
            RST_S: state_nx = T0;
            T0: begin
                PCout = 1'b1; MARin = 1'b1;
                state_nx = T1;
            end
            T1: begin
                Read = 1'b1; MDRin = 1'b1; IncPC = 1'b1; PCin = 1'b1;
                state_nx = T2;
            end
            T2: begin
                MDRout = 1'b1; IRin = 1'b1;
                state_nx = T3;
            end
            T3: begin
                state_nx = T4;
                if (is_alu || is_imm || is_mem) begin
                    Grb   = 1'b1;
                    Yin   = 1'b1;
                    Rout  = is_alu || (op == OP_ADDI);
                    BAout = is_mem || (op == OP_LDI);
                end else if (is_br) begin
                    Gra = 1'b1; Rout = 1'b1; CONin = 1'b1;
                end else begin
                    done = 1'b1;
                    case (op)
                        OP_JR:   begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
                        OP_IN:   begin INPORTout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                        OP_OUT:  begin Gra = 1'b1; Rout = 1'b1; OUTPORTin = 1'b1; end
                        OP_MFHI: begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                        OP_MFLO: begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                        default: ;
                    endcase
                end
            end
            T4: begin
                state_nx = T5;
                if (is_alu) begin
                    Grc = 1'b1; Rout = 1'b1; Zin = 1'b1;
                    case (op)
                        OP_SUB:  AluOp = ALUOP_W'(1);
                        OP_AND:  AluOp = ALUOP_W'(2);
                        OP_OR:   AluOp = ALUOP_W'(3);
                        default: AluOp = ALUOP_W'(0);
                    endcase
                end else if (is_imm || is_mem) begin
                    Cout = 1'b1; Zin = 1'b1;
                end else if (is_br) begin
                    PCout = 1'b1; Yin = 1'b1;
                end else begin
                    state_nx = T0;
                end
            end
            T5: begin
                state_nx = T6;
                if (is_alu || is_imm) begin
                    ZLOout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                    done = 1'b1;
                end else if (is_mem) begin
                    ZLOout = 1'b1; MARin = 1'b1;
                end else if (is_br) begin
                    Cout = 1'b1; Zin = 1'b1;
                end else begin
                    state_nx = T0;
                end
            end
            T6: begin
                state_nx = T7;
                if (op == OP_LD) begin
                    Read = 1'b1; MDRin = 1'b1;
                end else if (op == OP_ST) begin
                    Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
                end else if (is_br) begin
                    ZLOout = 1'b1; PCin = CON;
                    done = 1'b1;
                end else begin
                    state_nx = T0;
                end
            end
            T7: begin
                done = 1'b1;
                if (op == OP_LD) begin
                    MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (op == OP_ST) begin
                    write = 1'b1;
                end
            end
            HALTED: state_nx = HALTED;
`ifdef CTRL_SINGLE_STEP_EN
            PAUSE: begin
                if (stop_now)  state_nx = HALTED;
                else if (Step) state_nx = T0;
            end
`endif
            default: state_nx = RST_S;
        endcase

        if (done) begin
            if (stop_now || (op == OP_HALT)) state_nx = HALTED;
`ifdef CTRL_SINGLE_STEP_EN
            else                             state_nx = PAUSE;
`else
            else                             state_nx = T0;
`endif
        end

        InstrDone = done;
        Run       = !((state == RST_S) || (state == HALTED) || (state == PAUSE));
    end

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - self-checking bench for control_sequencer against a microprogram-table model
module tb_control_sequencer;

    logic        Clock = 1'b0;
    logic        Reset, CON, Stop, Step;
    logic [31:0] IR;
    logic        Run, InstrDone;
    logic [3:0]  AluOp;
    logic        PCin, MDRin, Zin, Yin, MARin, IRin, CONin, HIin, LOin, OUTPORTin;
    logic        PCout, MDRout, ZLOout, ZHIout, HIout, LOout, INPORTout, Cout;
    logic        Gra, Grb, Grc, Rin, Rout, BAout;
    logic        Read, IncPC, write;

    int checks = 0;
    int errors = 0;

    always #5 Clock = ~Clock;

    control_sequencer dut (
        .Clock(Clock), .Reset(Reset), .IR(IR), .CON(CON), .Stop(Stop),
`ifdef CTRL_SINGLE_STEP_EN
        .Step(Step),
`endif
        .Run(Run), .InstrDone(InstrDone), .AluOp(AluOp),
        .PCin(PCin), .MDRin(MDRin), .Zin(Zin), .Yin(Yin), .MARin(MARin), .IRin(IRin),
        .CONin(CONin), .HIin(HIin), .LOin(LOin), .OUTPORTin(OUTPORTin),
        .PCout(PCout), .MDRout(MDRout), .ZLOout(ZLOout), .ZHIout(ZHIout), .HIout(HIout),
        .LOout(LOout), .INPORTout(INPORTout), .Cout(Cout),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .Read(Read), .IncPC(IncPC), .write(write)
    );

    // Control word: one bit per control line, PCin at bit 0 up to write at bit 26.
    logic [26:0] obs_cw;
    assign obs_cw = {write, IncPC, Read, BAout, Rout, Rin, Grc, Grb, Gra, Cout, INPORTout, LOout,
                     HIout, ZHIout, ZLOout, MDRout, PCout, OUTPORTin, LOin, HIin, CONin, IRin,
                     MARin, Yin, Zin, MDRin, PCin};

    localparam logic [26:0] C_PCIN = 27'd1 << 0,  C_MDRIN = 27'd1 << 1,  C_ZIN = 27'd1 << 2;
    localparam logic [26:0] C_YIN = 27'd1 << 3,   C_MARIN = 27'd1 << 4,  C_IRIN = 27'd1 << 5;
    localparam logic [26:0] C_CONIN = 27'd1 << 6, C_OUTPIN = 27'd1 << 9, C_PCOUT = 27'd1 << 10;
    localparam logic [26:0] C_MDROUT = 27'd1 << 11, C_ZLOOUT = 27'd1 << 12, C_HIOUT = 27'd1 << 14;
    localparam logic [26:0] C_LOOUT = 27'd1 << 15, C_INPOUT = 27'd1 << 16, C_COUT = 27'd1 << 17;
    localparam logic [26:0] C_GRA = 27'd1 << 18, C_GRB = 27'd1 << 19, C_GRC = 27'd1 << 20;
    localparam logic [26:0] C_RIN = 27'd1 << 21, C_ROUT = 27'd1 << 22, C_BAOUT = 27'd1 << 23;
    localparam logic [26:0] C_READ = 27'd1 << 24, C_INCPC = 27'd1 << 25, C_WRITE = 27'd1 << 26;

    // Expected microprogram of the instruction under test.
    logic [26:0] exp_cw  [8];
    logic [3:0]  exp_alu [8];
    int          exp_len;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Builds the step-by-step control words of one instruction from the instruction table.
    task automatic build(input logic [4:0] op, input logic con);
        for (int i = 0; i < 8; i++) begin
            exp_cw[i]  = '0;
            exp_alu[i] = '0;
        end
        exp_cw[0] = C_PCOUT | C_MARIN;
        exp_cw[1] = C_READ | C_MDRIN | C_INCPC | C_PCIN;
        exp_cw[2] = C_MDROUT | C_IRIN;
        exp_len   = 4;
        case (op)
            5'b00011, 5'b00100, 5'b01010, 5'b01011: begin
                exp_len    = 6;
                exp_cw[3]  = C_GRB | C_ROUT | C_YIN;
                exp_cw[4]  = C_GRC | C_ROUT | C_ZIN;
                exp_alu[4] = (op == 5'b00100) ? 4'd1 : (op == 5'b01010) ? 4'd2 :
                             (op == 5'b01011) ? 4'd3 : 4'd0;
                exp_cw[5]  = C_ZLOOUT | C_GRA | C_RIN;
            end
            5'b01100, 5'b00001: begin
                exp_len   = 6;
                exp_cw[3] = C_GRB | C_YIN | ((op == 5'b01100) ? C_ROUT : C_BAOUT);
                exp_cw[4] = C_COUT | C_ZIN;
                exp_cw[5] = C_ZLOOUT | C_GRA | C_RIN;
            end
            5'b00000, 5'b00010: begin
                exp_len   = 8;
                exp_cw[3] = C_GRB | C_BAOUT | C_YIN;
                exp_cw[4] = C_COUT | C_ZIN;
                exp_cw[5] = C_ZLOOUT | C_MARIN;
                exp_cw[6] = (op == 5'b00000) ? (C_READ | C_MDRIN) : (C_GRA | C_ROUT | C_MDRIN);
                exp_cw[7] = (op == 5'b00000) ? (C_MDROUT | C_GRA | C_RIN) : C_WRITE;
            end
            5'b10011: begin
                exp_len   = 7;
                exp_cw[3] = C_GRA | C_ROUT | C_CONIN;
                exp_cw[4] = C_PCOUT | C_YIN;
                exp_cw[5] = C_COUT | C_ZIN;
                exp_cw[6] = C_ZLOOUT | (con ? C_PCIN : 27'd0);
            end
            5'b10100: exp_cw[3] = C_GRA | C_ROUT | C_PCIN;
            5'b10110: exp_cw[3] = C_INPOUT | C_GRA | C_RIN;
            5'b10111: exp_cw[3] = C_GRA | C_ROUT | C_OUTPIN;
            5'b11000: exp_cw[3] = C_HIOUT | C_GRA | C_RIN;
            5'b11001: exp_cw[3] = C_LOOUT | C_GRA | C_RIN;
            default:  exp_cw[3] = '0;
        endcase
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_cw"}, 32'(obs_cw), 32'd0);
        check({tag, "_run"}, 32'(Run), 32'd0);
        check({tag, "_done"}, 32'(InstrDone), 32'd0);
        check({tag, "_alu"}, 32'(AluOp), 32'd0);
    endtask

    // Runs one instruction starting at T0; optional Stop pulse at step stop_k and reset at step abort_k.
    task automatic run_instr(input string tag, input logic [31:0] ir, input logic con,
                             input int stop_k, input int abort_k);
        build(ir[31:27], con);
        for (int k = 0; k < exp_len; k++) begin
            @(negedge Clock);
            if (k == 0) begin
                IR   = ir;
                CON  = con;
                Step = 1'b0;
            end
            Stop = (k == stop_k);
            check($sformatf("%s_t%0d_cw", tag, k), 32'(obs_cw), 32'(exp_cw[k]));
            check($sformatf("%s_t%0d_alu", tag, k), 32'(AluOp), 32'(exp_alu[k]));
            check($sformatf("%s_t%0d_done", tag, k), 32'(InstrDone), 32'(k == exp_len - 1));
            check($sformatf("%s_t%0d_run", tag, k), 32'(Run), 32'd1);
            if (k == abort_k) begin
                Reset = 1'b1;
                #1;
                check_idle({tag, "_abort"});
                @(negedge Clock);
                check_idle({tag, "_abort2"});
                Reset = 1'b0;
                return;
            end
        end
`ifdef CTRL_SINGLE_STEP_EN
        if (stop_k < 0 && ir[31:27] != 5'b11011) begin
            @(negedge Clock);
            check_idle({tag, "_pause"});
            Step = 1'b1;
        end
`endif
    endtask

    task automatic check_halted(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge Clock);
            Stop = 1'b0;
            check_idle($sformatf("%s_h%0d", tag, i));
        end
    endtask

    task automatic do_reset(input string tag);
        @(negedge Clock);
        Reset = 1'b1;
        #1;
        check_idle({tag, "_a"});
        @(negedge Clock);
        check_idle({tag, "_b"});
        Reset = 1'b0;
    endtask

    initial begin
        logic [31:0] r;
        logic [4:0]  op;
        Reset = 1'b1; IR = '0; CON = 1'b0; Stop = 1'b0; Step = 1'b0;
        @(negedge Clock);
        check_idle("rst1");
        @(negedge Clock);
        check_idle("rst2");
        Reset = 1'b0;

        run_instr("add", 32'h19900000, 1'b0, -1, -1);
        run_instr("br_c0", {5'b10011, 27'h0123456}, 1'b0, -1, -1);
        run_instr("br_c1", {5'b10011, 27'h0654321}, 1'b1, -1, -1);
        run_instr("st", {5'b00010, 27'h1234567}, 1'b0, -1, -1);
        run_instr("ld", {5'b00000, 27'h7654321}, 1'b1, -1, -1);

        for (int n = 0; n < 60; n++) begin
            r  = $urandom();
            op = r[31:27];
            if (op == 5'b11011) r[31:27] = 5'b11010;
            run_instr($sformatf("rnd%0d", n), r, 1'($urandom_range(0, 1)), -1, -1);
        end

        run_instr("add_stop", {5'b00011, 27'h0}, 1'b0, 4, -1);
        check_halted("stop", 10);
        do_reset("rst_after_stop");
        run_instr("sub_post", {5'b00100, 27'h0abcdef}, 1'b0, -1, -1);
        run_instr("or_post", {5'b01011, 27'h0fedcba}, 1'b0, -1, -1);

        run_instr("st_abort", {5'b00010, 27'h0000001}, 1'b0, -1, 6);
        run_instr("jr_post", {5'b10100, 27'h0}, 1'b0, -1, -1);

        run_instr("halt", {5'b11011, 27'h0}, 1'b0, -1, -1);
        check_halted("halt", 4);
        do_reset("rst_after_halt");

        run_instr("halt_stop", {5'b11011, 27'h0}, 1'b0, 3, -1);
        check_halted("halt_stop", 3);
        do_reset("rst_final");
        run_instr("mflo_final", {5'b11001, 27'h0}, 1'b0, -1, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
